// File: rtl/data_coll_seq.sv
// Capture sequencer: arm -> trigger -> optional delay -> depth-sample write window.
// Optional macro DATA_COLL_SEQ_EXT_TRIG_EN adds an ext_trig rising-edge trigger.
module data_coll_seq #(
  parameter int unsigned DEPTH_WIDTH = 16,
  parameter int unsigned DELAY_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   arm,
  input  logic                   abort,
  input  logic [DEPTH_WIDTH-1:0] depth,
  input  logic [DELAY_WIDTH-1:0] delay,
  input  logic                   sw_trig,
  input  logic                   ext_trig,
  output logic                   we,
  output logic [DEPTH_WIDTH-1:0] wr_cnt,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted
);

  typedef enum logic [2:0] {IDLE, ARMED, DELAY, CAPTURE, FINISH} state_t;

  state_t                 state;
  logic [DEPTH_WIDTH-1:0] depth_q;
  logic [DELAY_WIDTH-1:0] delay_q;
  logic [DELAY_WIDTH-1:0] dly_cnt;
  logic                   trig;

`ifdef DATA_COLL_SEQ_EXT_TRIG_EN
  logic ext_prev;

  // Tracks ext_trig in every state so a level already high at arm time is not an edge.
  always_ff @(posedge clk) begin
    if (!resetn) ext_prev <= 1'b0;
    else         ext_prev <= ext_trig;
  end

  assign trig = sw_trig | (ext_trig & ~ext_prev);
`else
  logic unused_ext_trig;
  assign unused_ext_trig = ext_trig;
  assign trig = sw_trig;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      depth_q <= '0;
      delay_q <= '0;
      dly_cnt <= '0;
      wr_cnt  <= '0;
      we      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (abort && state != IDLE) begin
        // A sample written in the abort cycle still counts.
        if (state == CAPTURE) wr_cnt <= wr_cnt + DEPTH_WIDTH'(1);
        state   <= IDLE;
        we      <= 1'b0;
        busy    <= 1'b0;
        aborted <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (arm && depth != '0) begin
              depth_q <= depth;
              delay_q <= delay;
              wr_cnt  <= '0;
              state   <= ARMED;
              busy    <= 1'b1;
            end
          end
          ARMED: begin
            if (trig) begin
              if (delay_q == '0) begin
                state <= CAPTURE;
                we    <= 1'b1;
              end else begin
                state   <= DELAY;
                dly_cnt <= delay_q;
              end
            end
          end
          DELAY: begin
            if (dly_cnt == DELAY_WIDTH'(1)) begin
              state <= CAPTURE;
              we    <= 1'b1;
            end else begin
              dly_cnt <= dly_cnt - DELAY_WIDTH'(1);
            end
          end
          CAPTURE: begin
            wr_cnt <= wr_cnt + DEPTH_WIDTH'(1);
            if (wr_cnt + DEPTH_WIDTH'(1) == depth_q) begin
              state <= FINISH;
              we    <= 1'b0;
              done  <= 1'b1;
            end
          end
          FINISH: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            we    <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_coll_seq.sv
// Scoreboard bench for data_coll_seq: stimulus queues expected output cycles, a monitor checks them.
module tb_data_coll_seq;

  logic        clk = 1'b0;
  logic        resetn;
  logic        arm, abort, sw_trig, ext_trig;
  logic [15:0] depth, delay;
  logic        we, busy, done, aborted;
  logic [15:0] wr_cnt;

  data_coll_seq #(.DEPTH_WIDTH(16), .DELAY_WIDTH(16)) dut (
    .clk(clk), .resetn(resetn), .arm(arm), .abort(abort), .depth(depth), .delay(delay),
    .sw_trig(sw_trig), .ext_trig(ext_trig), .we(we), .wr_cnt(wr_cnt), .busy(busy),
    .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic we;
    int   wr_cnt;
    logic done;
    logic aborted;
    logic busy;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cycle with any activity output must match the head of the queue.
  always @(negedge clk) begin
    if (we === 1'b1 || done === 1'b1 || aborted === 1'b1) begin
      nvec++;
      if (q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_output cyc=%0d we=%b wr_cnt=%0d done=%b aborted=%b busy=%b",
                 cyc, we, wr_cnt, done, aborted, busy);
      end else begin
        e = q.pop_front();
        if (cyc !== e.cyc || we !== e.we || int'(wr_cnt) !== e.wr_cnt || done !== e.done ||
            aborted !== e.aborted || busy !== e.busy) begin
          nerr++;
          $display("FAIL scoreboard actual cyc=%0d we=%b wr_cnt=%0d done=%b aborted=%b busy=%b required cyc=%0d we=%b wr_cnt=%0d done=%b aborted=%b busy=%b",
                   cyc, we, wr_cnt, done, aborted, busy,
                   e.cyc, e.we, e.wr_cnt, e.done, e.aborted, e.busy);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic chk(input string name, input int act, input int req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input int c, input logic w, input int n, input logic d, input logic a,
                      input logic b);
    exp_t x;
    x.cyc = c; x.we = w; x.wr_cnt = n; x.done = d; x.aborted = a; x.busy = b;
    q.push_back(x);
  endtask

  // Expected window: first we at t0, abort_at = index of the we cycle carrying abort (-1: none).
  task automatic push_capture(input int t0, input int d, input int abort_at);
    for (int i = 0; i < d; i++) begin
      if (abort_at >= 0 && i > abort_at) break;
      push(t0 + i, 1'b1, i, 1'b0, 1'b0, 1'b1);
    end
    if (abort_at >= 0) push(t0 + abort_at + 1, 1'b0, abort_at + 1, 1'b0, 1'b1, 1'b0);
    else               push(t0 + d, 1'b0, d, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic do_arm(input int d, input int l);
    arm = 1'b1; depth = 16'(d); delay = 16'(l);
    tick();
    arm = 1'b0;
  endtask

  task automatic fire(output int t);
    sw_trig = 1'b1;
    t = cyc;
    tick();
    sw_trig = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    resetn = 1'b0; arm = 1'b0; abort = 1'b0; sw_trig = 1'b0; ext_trig = 1'b0;
    depth = '0; delay = '0;
    repeat (3) tick();
    chk("rst_we", int'(we), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_aborted", int'(aborted), 0);
    chk("rst_wr_cnt", int'(wr_cnt), 0);
    resetn = 1'b1;
    tick();

    // depth 8, delay 0: we T+1..T+8, done T+9, idle T+10
    do_arm(8, 0);
    chk("armed_busy", int'(busy), 1);
    tick();
    t = cyc;
    push_capture(t + 1, 8, -1);
    fire(t);
    run_to(t + 9);
    chk("finish_busy", int'(busy), 1);
    tick();
    chk("idle_busy_T10", int'(busy), 0);
    chk("wr_cnt_hold", int'(wr_cnt), 8);

    // depth 4, delay 5: we T+6..T+9, done T+10; arm clears wr_cnt
    do_arm(4, 5);
    chk("arm_clears_wr_cnt", int'(wr_cnt), 0);
    t = cyc;
    push_capture(t + 6, 4, -1);
    fire(t);
    run_to(t + 11);
    chk("delay_done_busy", int'(busy), 0);

    // arm and new depth/delay during CAPTURE must not disturb the capture
    do_arm(4, 2);
    t = cyc;
    push_capture(t + 3, 4, -1);
    fire(t);
    run_to(t + 4);
    arm = 1'b1; depth = 16'd9; delay = 16'd1;
    tick();
    arm = 1'b0;
    run_to(t + 9);
    chk("arm_in_capture_busy", int'(busy), 0);
    chk("arm_in_capture_wr_cnt", int'(wr_cnt), 4);

    // depth 0 arm is ignored; trigger in IDLE does nothing
    do_arm(0, 0);
    chk("depth0_busy", int'(busy), 0);
    sw_trig = 1'b1;
    tick();
    sw_trig = 1'b0;
    repeat (3) tick();
    chk("idle_trig_busy", int'(busy), 0);

    // abort at 6th we cycle of depth-16 capture
    do_arm(16, 0);
    t = cyc;
    push_capture(t + 1, 16, 5);
    fire(t);
    run_to(t + 6);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_we", int'(we), 0);
    chk("abort_wr_cnt", int'(wr_cnt), 6);
    chk("abort_busy", int'(busy), 0);
    repeat (3) tick();
    chk("abort_wr_cnt_frozen", int'(wr_cnt), 6);
    do_arm(2, 0);
    chk("rearm_clears_wr_cnt", int'(wr_cnt), 0);

    // abort while ARMED
    push(cyc + 1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_armed_busy", int'(busy), 0);

    // abort alone in IDLE: no pulse; abort+arm in IDLE: arm wins
    abort = 1'b1;
    tick();
    chk("abort_idle_busy", int'(busy), 0);
    arm = 1'b1; depth = 16'd3; delay = '0;
    tick();
    arm = 1'b0; abort = 1'b0;
    chk("arm_abort_coincide_busy", int'(busy), 1);

    // abort on last sample wins over done
    t = cyc;
    push_capture(t + 1, 3, 2);
    fire(t);
    run_to(t + 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_last_wr_cnt", int'(wr_cnt), 3);
    tick();
    chk("abort_last_busy", int'(busy), 0);

    // ext_trig level high before arm is not a trigger
    ext_trig = 1'b1;
    repeat (2) tick();
    do_arm(2, 1);
    repeat (3) tick();
    chk("ext_level_no_trig", int'(we), 0);
    ext_trig = 1'b0;
    tick();
    ext_trig = 1'b1;
    t = cyc;
`ifdef DATA_COLL_SEQ_EXT_TRIG_EN
    push_capture(t + 2, 2, -1);
    tick();
    run_to(t + 6);
    chk("ext_edge_done_busy", int'(busy), 0);
`else
    repeat (5) tick();
    chk("ext_ignored_busy", int'(busy), 1);
    push(cyc + 1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
`endif
    ext_trig = 1'b0;
    tick();

    // synchronous reset mid-capture
    do_arm(10, 0);
    t = cyc;
    for (int i = 0; i < 4; i++) push(t + 1 + i, 1'b1, i, 1'b0, 1'b0, 1'b1);
    fire(t);
    run_to(t + 4);
    resetn = 1'b0;
    tick();
    chk("midrst_we", int'(we), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_aborted", int'(aborted), 0);
    chk("midrst_wr_cnt", int'(wr_cnt), 0);
    resetn = 1'b1;
    repeat (5) tick();
    chk("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/data_coll_seq.md
DATA_COLL_SEQ -- requirements
Module: data_coll_seq

Interface
REQ-001 Parameter DEPTH_WIDTH, default 16, width of the capture-depth count.
REQ-002 Parameter DELAY_WIDTH, default 16, width of the post-trigger delay count.
REQ-003 The port list SHALL be, in this order:
- clk  in  1  single clock; all logic on its rising edge.
- resetn  in  1  reset, synchronous, active-low.
- arm  in  1  one-cycle pulse; arm the sequencer.
- abort  in  1  one-cycle pulse; cancel any operation.
- depth  in  DEPTH_WIDTH  number of samples to capture.
- delay  in  DELAY_WIDTH  cycles from trigger to first sample.
- sw_trig  in  1  software trigger pulse.
- ext_trig  in  1  external trigger level, already synchronous to clk.
- we  out  1  write-enable window to the data collector.
- wr_cnt  out  DEPTH_WIDTH  samples written in the current capture.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a capture completes.
- aborted  out  1  one-cycle pulse when an abort is accepted.

Function
REQ-004 All outputs SHALL be registered.
REQ-005 The FSM SHALL have exactly five states: IDLE, ARMED, DELAY, CAPTURE, FINISH.
REQ-006 In IDLE, arm=1 with depth!=0 SHALL latch depth and delay and go to ARMED; arm with depth==0 SHALL be ignored.
REQ-007 In ARMED, a trigger SHALL go to CAPTURE if the latched delay==0, otherwise to DELAY.
- Trigger = sw_trig OR ext rising edge (see REQ-017).
REQ-008 DELAY SHALL count the latched delay cycles and then enter CAPTURE, so the first we-high cycle is exactly 1+delay cycles after the trigger cycle.
REQ-009 In CAPTURE:
- we=1 for exactly the latched depth consecutive cycles.
- wr_cnt increments by 1 per we-high cycle.
- After the last sample, go to FINISH.
REQ-010 FINISH SHALL assert done for one cycle, clear we, and return to IDLE on the next cycle.
REQ-011 wr_cnt SHALL hold its final value after done and SHALL clear to 0 when the next accepted arm occurs.
REQ-012 arm, sw_trig and ext edges outside their qualifying states (REQ-006, REQ-007) SHALL be ignored; new depth or delay values during a capture SHALL NOT affect it.
REQ-013 abort in any non-IDLE state SHALL:
- go to IDLE on the next edge and deassert we there;
- pulse aborted once;
- not pulse done;
- freeze wr_cnt.
REQ-014 abort in IDLE SHALL have no effect; if abort and arm coincide in IDLE, the arm is accepted.
REQ-015 abort in the same cycle as the last CAPTURE sample SHALL win: no done, and wr_cnt=depth.

Reset
REQ-016 While resetn=0 at a clk edge:
- state=IDLE;
- we=0, busy=0, done=0, aborted=0;
- wr_cnt=0, latched depth=0, latched delay=0;
- the ext edge register=0.
A reset mid-capture SHALL behave like REQ-016 with no done or aborted pulse.

Configuration
REQ-017 Macro DATA_COLL_SEQ_EXT_TRIG_EN.
- Defined: an ext_trig rising edge (ext_trig=1 and previous-cycle ext_trig=0) is a trigger. The previous-cycle register tracks ext_trig in all states, so a level already high before ARMED is not a trigger.
- Undefined: ext_trig is ignored, no edge register is built, and only sw_trig triggers.

Verification
REQ-018 arm depth=8 delay=0, sw_trig at cycle T -> we high cycles T+1..T+8, wr_cnt=8, done at T+9, busy low at T+10.
REQ-019 arm depth=4 delay=5, sw_trig at T -> we high T+6..T+9, done at T+10.
REQ-020 With EXT_TRIG_EN defined, ext_trig held high before arm -> no capture; drop low then raise at T -> we starts at T+1+delay. Without the macro, the same stimulus never triggers.
REQ-021 depth=16 capture, abort at the 6th we cycle -> we low next cycle, wr_cnt=6, aborted pulse, no done; new arm clears wr_cnt to 0.
REQ-022 Checks for ignored and edge-case inputs:
- arm with depth=0 -> busy stays 0.
- arm during CAPTURE -> no effect.
- resetn=0 mid-capture -> all outputs at reset values on the next cycle.
